// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the fetch PC, issues reads to the
// instruction cache, and holds each returned word for decode. On acceptance it
// applies decode's next-PC select.
// Optional feature macro: FETCH_PREFETCH_EN (one-entry sequential prefetch buffer).
//
// Handshake: ins/pc/npc are offered while ins_valid=1 and must stay stable until
// the cycle where ins_valid & ins_ready are both high (acceptance). ins_ready
// while ins_valid=0 has no effect.

package fetch_unit_pkg;
  typedef enum logic [1:0] {
    PC_NPC  = 2'd0,
    PC_BR   = 2'd1,
    PC_JUMP = 2'd2,
    PC_JR   = 2'd3
  } pcMux;
endpackage

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  input  logic        dmem_busy,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  pcMux        pcSel,
  input  logic [31:0] rdat1,
  input  logic        halt_in,
  output logic [31:0] pc,
  output logic [31:0] npc,
  output logic        halted,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_fpc, w_fpc_next;
  logic [31:0] r_ins, w_ins_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] w_npc;
  logic [31:0] w_target;
  logic        w_accept;

`ifdef FETCH_PREFETCH_EN
  logic        r_pf_valid, w_pf_valid_next;
  logic [31:0] r_pf_data, w_pf_data_next;
  logic [31:0] r_pf_addr, w_pf_addr_next;
  logic        w_pf_hit;
  logic        w_is_npc;
`endif

  assign w_npc       = r_pc + 32'd4;
  assign w_accept    = (r_state == HOLD) && ins_ready;
  assign ins         = r_ins;
  assign pc          = r_pc;
  assign npc         = w_npc;
  assign ins_valid   = (r_state == HOLD);
  assign halted      = (r_state == HALTED);
  assign o_dbg_state = r_state;

  // Next-PC target from decode's select; unknown encodings fall back to sequential.
  always_comb begin
    w_target = w_npc;
`ifdef FETCH_PREFETCH_EN
    w_is_npc = 1'b1;
`endif
    case (pcSel)
      PC_BR: begin
        w_target = w_npc + {{14{r_ins[15]}}, r_ins[15:0], 2'b00};
`ifdef FETCH_PREFETCH_EN
        w_is_npc = 1'b0;
`endif
      end
      PC_JUMP: begin
        w_target = {w_npc[31:28], r_ins[25:0], 2'b00};
`ifdef FETCH_PREFETCH_EN
        w_is_npc = 1'b0;
`endif
      end
      PC_JR: begin
        w_target = rdat1;
`ifdef FETCH_PREFETCH_EN
        w_is_npc = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Fetch FSM next state, cache request and register next values.
  always_comb begin
    w_state_next = r_state;
    w_fpc_next   = r_fpc;
    w_ins_next   = r_ins;
    w_pc_next    = r_pc;
    imemREN      = 1'b0;
    imemaddr     = r_fpc;
`ifdef FETCH_PREFETCH_EN
    w_pf_valid_next = r_pf_valid;
    w_pf_data_next  = r_pf_data;
    w_pf_addr_next  = r_pf_addr;
    w_pf_hit        = 1'b0;
`endif
    case (r_state)
      FETCH: begin
        imemREN = !dmem_busy;
        if (ihit && !dmem_busy) begin
          w_ins_next   = iload;
          w_pc_next    = r_fpc;
          w_state_next = HOLD;
        end
      end
      HOLD: begin
`ifdef FETCH_PREFETCH_EN
        // Prefetch the sequential successor; a redirect or halt kills it at once.
        imemaddr = w_npc;
        imemREN  = !r_pf_valid && !dmem_busy &&
                   !(w_accept && (halt_in || !w_is_npc));
        w_pf_hit = imemREN && ihit;
        if (w_pf_hit) begin
          w_pf_valid_next = 1'b1;
          w_pf_data_next  = iload;
          w_pf_addr_next  = w_npc;
        end
`endif
        if (w_accept) begin
          if (halt_in) begin
            w_state_next = HALTED;
`ifdef FETCH_PREFETCH_EN
            w_pf_valid_next = 1'b0;
`endif
          end else begin
`ifdef FETCH_PREFETCH_EN
            w_pf_valid_next = 1'b0;
            if (w_is_npc && r_pf_valid && (r_pf_addr == w_npc)) begin
              w_ins_next   = r_pf_data;
              w_pc_next    = w_npc;
              w_fpc_next   = w_npc;
              w_state_next = HOLD;
            end else if (w_is_npc && w_pf_hit) begin
              w_ins_next   = iload;
              w_pc_next    = w_npc;
              w_fpc_next   = w_npc;
              w_state_next = HOLD;
            end else begin
              w_fpc_next   = w_target;
              w_state_next = FETCH;
            end
`else
            w_fpc_next   = w_target;
            w_state_next = FETCH;
`endif
          end
        end
      end
      HALTED: ;
      default: w_state_next = FETCH;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= FETCH;
      r_fpc   <= PC_INIT;
      r_ins   <= 32'd0;
      r_pc    <= 32'd0;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid <= 1'b0;
      r_pf_data  <= 32'd0;
      r_pf_addr  <= 32'd0;
`endif
    end else begin
      r_state <= w_state_next;
      r_fpc   <= w_fpc_next;
      r_ins   <= w_ins_next;
      r_pc    <= w_pc_next;
`ifdef FETCH_PREFETCH_EN
      r_pf_valid <= w_pf_valid_next;
      r_pf_data  <= w_pf_data_next;
      r_pf_addr  <= w_pf_addr_next;
`endif
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: bench for fetch_unit (default build or FETCH_PREFETCH_EN).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [31:0] PC_INIT = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit;
  logic [31:0] iload;
  logic        dmem_busy;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  pcMux        pcSel;
  logic [31:0] rdat1;
  logic        halt_in;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        halted;
  logic [1:0]  dbg_state;

  // clock / reset block
  always #5 CLK = ~CLK;

  // cache model: manual pulses for directed tests, address-derived words otherwise
  logic        auto_en, hit_rand, man_ihit;
  logic [31:0] man_iload;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign ihit  = auto_en ? (imemREN & hit_rand) : man_ihit;
  assign iload = auto_en ? mem_word(imemaddr) : man_iload;

  fetch_unit #(.PC_INIT(PC_INIT)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .dmem_busy(dmem_busy),
    .imemREN(imemREN), .imemaddr(imemaddr), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .pcSel(pcSel), .rdat1(rdat1), .halt_in(halt_in),
    .pc(pc), .npc(npc), .halted(halted), .o_dbg_state(dbg_state)
  );

  // scoreboard counters
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_fetch_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference next-PC, straight from the arithmetic rules
  function automatic logic [31:0] model_next(input logic [31:0] cpc, input logic [31:0] w,
                                             input pcMux sel, input logic [31:0] r1);
    logic [31:0] n;
    shortint     imm;
    int          off;
    n = cpc + 32'd4;
    imm = shortint'(w[15:0]);
    off = int'(imm) * 4;
    case (sel)
      PC_BR:   return n + 32'(off);
      PC_JUMP: return (n & 32'hF000_0000) | ((w & 32'h03FF_FFFF) << 2);
      PC_JR:   return r1;
      default: return n;
    endcase
  endfunction

  // driver tasks (start and end at a falling edge)
  task automatic idle_inputs();
    man_ihit = 1'b0; man_iload = 32'd0; dmem_busy = 1'b0; ins_ready = 1'b0;
    pcSel = PC_NPC; rdat1 = 32'd0; halt_in = 1'b0; hit_rand = 1'b0;
  endtask

  task automatic reset_dut();
    auto_en = 1'b0;
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic fetch_word(input logic [31:0] addr, input logic [31:0] word);
    int waited = 0;
    #1;
    while (!imemREN && waited < 20) begin
      @(negedge CLK); #1; waited++;
    end
    chk("fetch_req", imemREN, 1);
    chk("fetch_addr", imemaddr, addr);
    man_ihit = 1'b1; man_iload = word;
    @(negedge CLK);
    man_ihit = 1'b0;
    #1;
    chk("fetch_valid", ins_valid, 1);
    chk("fetch_ins", ins, word);
    chk("fetch_pc", pc, addr);
    chk("fetch_npc", npc, addr + 32'd4);
  endtask

  task automatic accept(input pcMux sel, input logic [31:0] r1, input logic h);
    ins_ready = 1'b1; pcSel = sel; rdat1 = r1; halt_in = h;
    @(negedge CLK);
    ins_ready = 1'b0; pcSel = PC_NPC; halt_in = 1'b0;
  endtask

  task automatic chk_redirect(input string name, input logic [31:0] target);
    #1;
    chk({name, "_addr"}, imemaddr, target);
    chk({name, "_req"}, imemREN, 1);
    chk({name, "_valid"}, ins_valid, 0);
  endtask

  typedef struct {
    logic [31:0] pc_at;
    logic [31:0] word;
    pcMux        sel;
    logic [31:0] r1;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur;
    int cyc, accepts, t_first, t_last;

    vecs[0] = '{32'h0000_0040, 32'h1000_FFFE, PC_BR,   32'h0,       32'h0000_003C};
    vecs[1] = '{32'h0000_0040, 32'h0800_0100, PC_JUMP, 32'h0,       32'h0000_0400};
    vecs[2] = '{32'h0000_0040, 32'h0000_0008, PC_JR,   32'h80,      32'h0000_0080};
    vecs[3] = '{32'h0000_0040, 32'h0000_0000, PC_NPC,  32'h1234,    32'h0000_0044};
    vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, PC_NPC,  32'h0,       32'h0000_0000};
    vecs[5] = '{32'h0000_0100, 32'h1000_0010, PC_BR,   32'h0,       32'h0000_0144};
    vecs[6] = '{32'hF000_0000, 32'h0BFF_FFFF, PC_JUMP, 32'h0,       32'hFFFF_FFFC};
    vecs[7] = '{32'hFFFF_FFFC, 32'h1000_0001, PC_BR,   32'h0,       32'h0000_0004};
    vecs[8] = '{32'h0FFF_FFFC, 32'h0800_0004, PC_JUMP, 32'h0,       32'h1000_0010};

    auto_en = 1'b0;
    idle_inputs();
    nRST = 1'b0;
    @(negedge CLK);
    reset_dut();

    // reset state
    #1;
    chk("rst_req", imemREN, 1);
    chk("rst_addr", imemaddr, PC_INIT);
    chk("rst_valid", ins_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ins", ins, 0);
    chk("rst_pc", pc, 0);

    // first fetch and sequential redirect
    fetch_word(32'h0, 32'h2000_0001);
    accept(PC_NPC, 32'h0, 1'b0);
    chk_redirect("first_npc", 32'h4);
    cur = 32'h4;

    // next-PC vector table
    foreach (vecs[i]) begin
      fetch_word(cur, 32'h0);
      accept(PC_JR, vecs[i].pc_at, 1'b0);
      fetch_word(vecs[i].pc_at, vecs[i].word);
      accept(vecs[i].sel, vecs[i].r1, 1'b0);
      chk_redirect($sformatf("vec%0d", i), vecs[i].exp);
      cur = vecs[i].exp;
    end

    // move to a known address
    fetch_word(cur, 32'h0);
    accept(PC_JR, 32'h200, 1'b0);
    cur = 32'h200;

    // dmem_busy blocks the request and an ihit in the same cycle is ignored
    for (int k = 0; k < 3; k++) begin
      dmem_busy = 1'b1; man_ihit = 1'b1; man_iload = 32'hDEAD_BEEF;
      #1;
      chk("busy_req", imemREN, 0);
      @(negedge CLK);
    end
    dmem_busy = 1'b0; man_ihit = 1'b0;
    #1;
    chk("busy_valid", ins_valid, 0);
    chk("busy_retry_addr", imemaddr, cur);
    fetch_word(cur, 32'h0800_0200);

    // ins_ready low: presented instruction stays stable
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK); #1;
      chk("hold_ins", ins, 32'h0800_0200);
      chk("hold_pc", pc, cur);
      chk("hold_npc", npc, cur + 32'd4);
    end
`ifdef FETCH_PREFETCH_EN
    // fill the prefetch buffer, then redirect: the buffered word must never appear
    #1;
    chk("pf_req", imemREN, 1);
    chk("pf_addr", imemaddr, cur + 32'd4);
    man_ihit = 1'b1; man_iload = 32'hBAD0_BAD0;
    @(negedge CLK);
    man_ihit = 1'b0;
`endif
    accept(PC_JUMP, 32'h0, 1'b0);
    chk_redirect("jump_discard", 32'h800);
    fetch_word(32'h800, 32'h1111_1111);

    // halt: sticky, no requests regardless of inputs
    accept(PC_NPC, 32'h0, 1'b1);
    #1;
    chk("halt_flag", halted, 1);
    chk("halt_req", imemREN, 0);
    chk("halt_valid", ins_valid, 0);
    for (int k = 0; k < 20; k++) begin
      man_ihit = 1'($urandom_range(0, 1)); ins_ready = 1'($urandom_range(0, 1));
      halt_in = 1'($urandom_range(0, 1)); pcSel = pcMux'($urandom_range(0, 3));
      dmem_busy = 1'($urandom_range(0, 1));
      @(negedge CLK); #1;
      chk("halted_req", imemREN, 0);
      chk("halted_flag", halted, 1);
    end
    reset_dut();
    #1;
    chk("unhalt_flag", halted, 0);
    chk("unhalt_addr", imemaddr, PC_INIT);
    chk("unhalt_req", imemREN, 1);

    // sequential stream with ready held high and a zero-wait cache
    exp_q = '{32'h0, 32'h4, 32'h8};
    exp_fetch_q = '{32'h0, 32'h4, 32'h8};
    auto_en = 1'b1; hit_rand = 1'b1; ins_ready = 1'b1; pcSel = PC_NPC;
    accepts = 0; t_first = 0; t_last = 0;
    for (cyc = 0; cyc < 50 && accepts < 3; cyc++) begin
      #1;
      if (imemREN && ihit && exp_fetch_q.size() > 0)
        chk("seq_fetch_addr", imemaddr, exp_fetch_q.pop_front());
      if (ins_valid) begin
        chk("seq_pc", pc, exp_q.pop_front());
        if (accepts == 0) t_first = cyc;
        t_last = cyc;
        accepts++;
      end
      @(negedge CLK);
    end
    chk("seq_count", 32'(accepts), 3);
`ifdef FETCH_PREFETCH_EN
    chk("seq_spacing", 32'(t_last - t_first), 2);
`else
    chk("seq_spacing", 32'(t_last - t_first), 4);
`endif

    // randomized traffic against the transaction-level model
    reset_dut();
    auto_en = 1'b1;
    cur = PC_INIT;
    accepts = 0;
    for (cyc = 0; cyc < 20000 && accepts < 300; cyc++) begin
      hit_rand  = ($urandom_range(0, 3) != 0);
      dmem_busy = ($urandom_range(0, 3) == 0);
      ins_ready = 1'($urandom_range(0, 1));
      pcSel     = pcMux'($urandom_range(0, 3));
      rdat1     = $urandom & 32'hFFFF_FFFC;
      #1;
      if (dmem_busy) chk("rnd_busy_req", imemREN, 0);
      if (ins_valid) begin
        chk("rnd_pc", pc, cur);
        chk("rnd_ins", ins, mem_word(cur));
        chk("rnd_npc", npc, cur + 32'd4);
        if (ins_ready) begin
          cur = model_next(cur, mem_word(cur), pcSel, rdat1);
          accepts++;
        end
      end else begin
        chk("rnd_fetch_addr", imemaddr, cur);
        chk("rnd_fetch_req", imemREN, 32'(!dmem_busy));
      end
      @(negedge CLK);
    end
    chk("rnd_accept_count", 32'(accepts), 300);

    auto_en = 1'b0;
    idle_inputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle MIPS datapath, directly upstream of the decode unit. Owns the program counter, issues instruction reads to the cache, and registers each returned word with a valid/ready handshake. On acceptance it applies decode's next-PC selection:

- sequential (`PC_NPC`)
- branch (`PC_BR`)
- jump (`PC_JUMP`)
- jump-register (`PC_JR`)

## Interface

Parameters:
- `PC_INIT`, default `32'h0000_0000`: PC value loaded on reset.

Ports:
- `CLK`  in  1: sole clock; all state updates on the rising edge.
- `nRST`  in  1: reset, synchronous, active-low. One clock, no other clock domains.
- `ihit`  in  1: instruction cache returns `iload` this cycle.
- `iload`  in  32: instruction word from the cache.
- `dmem_busy`  in  1: a data access owns the cache port this cycle (decode `dREN|dWEN`).
- `imemREN`  out  1: instruction read request.
- `imemaddr`  out  32: instruction read address.
- `ins`  out  32: registered instruction presented to decode.
- `ins_valid`  out  1: `ins`, `pc` and `npc` are valid.
- `ins_ready`  in  1: decode consumes `ins` this cycle.
- `pcSel`  in  `pcMux`: decode's next-PC select, sampled only on acceptance.
- `rdat1`  in  32: register `rs` value, the `PC_JR` target.
- `halt_in`  in  1: decode flags the presented instruction as `HALT`.
- `pc`  out  32: address of `ins`.
- `npc`  out  32: `pc + 4`, used for `JAL` link.
- `halted`  out  1: processor halted, sticky until reset.

## Operation

States:
- `FETCH`: request outstanding.
- `HOLD`: instruction valid, awaiting acceptance.
- `HALTED`

State behaviour:
- `FETCH`:
  - `imemREN = !dmem_busy`, `imemaddr = fpc` (fetch PC register).
  - On `ihit & !dmem_busy`: `ins <= iload`, `pc <= fpc`, go to `HOLD`.
- `HOLD`:
  - `ins_valid = 1`. `ins`, `pc` and `npc` stay stable until acceptance.
- Acceptance: `ins_valid & ins_ready`.
  - If `halt_in`: go to `HALTED`, `fpc` unchanged.
  - Otherwise load `fpc` from the next-PC table below and go to `FETCH`.
- `HALTED`:
  - `imemREN = 0`, `ins_valid = 0`, `halted = 1`.
  - All inputs ignored until reset.

Next-PC table (all arithmetic 32-bit modulo 2^32; `npc = pc + 4`):
- `PC_NPC`: `npc`.
- `PC_BR`: `npc + {{14{ins[15]}}, ins[15:0], 2'b00}`.
- `PC_JUMP`: `{npc[31:28], ins[25:0], 2'b00}`.
- `PC_JR`: `rdat1`.
- Any other/X encoding: treated as `PC_NPC`.

Boundary conditions:
- `ihit` with `dmem_busy` in the same cycle: ignored, request retried next cycle.
- `ins_ready` while `ins_valid = 0`: no effect.
- PC wrap: `32'hFFFF_FFFC + 4` gives `0`.

## Timing

- Reset (`nRST` low at the edge), outputs one cycle later:
  - state `FETCH`, `fpc = PC_INIT`
  - `ins = 0`, `pc = 0`, `ins_valid = 0`, `halted = 0`
  - prefetch buffer empty (when the prefetch feature is compiled in)
- Reset takes priority over every event, including mid-request and `HALTED`.
- `imemREN` and `imemaddr` are combinational from state, `fpc` and `dmem_busy`. The request is high in the first cycle after reset.
- Fetch latency: `ihit` at edge n gives `ins_valid = 1` from cycle n+1.
- Acceptance at edge m: `ins_valid = 0` and `imemREN = 1` at `imemaddr = target` from cycle m+1, so there is a minimum 2 cycles between consecutive instructions.
- `halted` rises the cycle after `HALT` is accepted.

## Configuration

`FETCH_PREFETCH_EN`

Defined:
- While in `HOLD`, the unit also requests `pc + 4` into a one-entry prefetch buffer, tagged with its address.
- The prefetch request uses the same `dmem_busy` gating as `FETCH`.
- On acceptance with `pcSel == PC_NPC`:
  - If the buffer holds `npc`, the buffered word is presented the next cycle (back-to-back issue, no `FETCH` cycle).
  - If the prefetch is still outstanding, go to `FETCH` at `npc`.
- Any other `pcSel`, or `halt_in`, discards the buffer and any outstanding prefetch; `imemREN` is dropped immediately.

Undefined:
- No buffer; behaviour exactly as in Operation.

## Test plan

- Reset with `PC_INIT = 0`, `ihit` one cycle after `imemREN` -> `imemaddr = 0`, then `ins_valid = 1` with `pc = 0`, `npc = 4`.
- Sequential stream at addresses 0, 4, 8 with `ins_ready` held high -> three instructions presented:
  - `imemaddr` sequence 0, 4, 8
  - 2 cycles per instruction without `FETCH_PREFETCH_EN`
  - 1 cycle per instruction with `FETCH_PREFETCH_EN` and a zero-wait cache
- `BEQ` at `pc = 0x40`, `imm = 0xFFFE`, `pcSel = PC_BR` -> next `imemaddr = 0x3C`. Also: `J` with `ins[25:0] = 0x100` at `pc = 0x40` -> `0x400`. Also: `JR` with `rdat1 = 0x80` -> `0x80`.
- `dmem_busy` high for 3 cycles while `ihit` pulses -> `imemREN = 0`, the `ihit` is ignored, and the same address is refetched after `dmem_busy` falls.
- `HALT` presented, `halt_in = 1`, `ins_ready = 1` -> `halted = 1` next cycle and `imemREN` stays 0 for 20 cycles. Then `nRST` low -> `halted = 0`, `imemaddr = PC_INIT`.
- `ins_ready` held low for 5 cycles -> `ins`, `pc` and `npc` stable throughout. With `FETCH_PREFETCH_EN`: `pcSel = PC_JUMP` on acceptance -> the prefetched word is never presented.
